// File: rtl/clk_div_pkg.sv
// Shared constants, channel state encoding and helpers for the clock divider bank.
package clk_div_pkg;
  localparam int C_CH_NUM   = 4;
  localparam int C_CNT_W    = 16;
  localparam int C_DIV_INIT = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

  // Channel-select width; a single-channel bank still carries a 1-bit select.
  function automatic int f_ch_w(input int ch_num);
    return (ch_num > 1) ? $clog2(ch_num) : 1;
  endfunction

  // High time of one period, ceil(div/2): odd ratios get the extra high cycle.
  function automatic logic [31:0] f_hi_cnt(input logic [31:0] div);
    return div - (div >> 1);
  endfunction
endpackage

// File: rtl/clk_div_bank_if.sv
// Divisor write port of the clock divider bank: valid/ready handshake plus
// target channel and new divisor.
interface clk_div_bank_if
  import clk_div_pkg::*;
#(
  parameter int P_CH_NUM = C_CH_NUM,
  parameter int P_CNT_W  = C_CNT_W
);
  localparam int CH_W = f_ch_w(P_CH_NUM);

  logic               i_cfg_valid;
  logic [CH_W-1:0]    i_cfg_ch;
  logic [P_CNT_W-1:0] i_cfg_div;
  logic               o_cfg_ready;

  modport master (output i_cfg_valid, i_cfg_ch, i_cfg_div, input o_cfg_ready);
  modport slave  (input i_cfg_valid, i_cfg_ch, i_cfg_div, output o_cfg_ready);
endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: period counter, IDLE/RUN state and pending divisor.
// The o_rise_stb port exists only when CLK_DIV_STB_EN is defined.
//
// state   | meaning
// ST_IDLE | stopped, output 0, a pending divisor is applied at once
// ST_RUN  | counting 0..div-1, output high while cnt < ceil(div/2)
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int P_CNT_W    = C_CNT_W,
  parameter int P_DIV_INIT = C_DIV_INIT
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_wr,
  input  logic [P_CNT_W-1:0] i_wr_div,
  output logic               o_pend_vld,
  output logic               o_clk
`ifdef CLK_DIV_STB_EN
  ,
  output logic               o_rise_stb
`endif
);
  localparam logic [P_CNT_W-1:0] C_DIV_RST = P_CNT_W'(P_DIV_INIT);
  localparam logic [P_CNT_W-1:0] C_DIV_MIN = P_CNT_W'(2);
  localparam logic [P_CNT_W-1:0] C_ONE     = P_CNT_W'(1);

  ch_state_e          r_state;
  ch_state_e          w_state_nxt;
  logic [P_CNT_W-1:0] r_cnt;
  logic [P_CNT_W-1:0] r_div;
  logic [P_CNT_W-1:0] r_pend_div;
  logic               r_pend_vld;
  logic               r_clk;
  logic [P_CNT_W-1:0] w_hi;
  logic [P_CNT_W-1:0] w_div_eff;
  logic               w_wrap;
  logic               w_apply;
  logic               w_cnt_clr;
  logic               w_clk_nxt;
`ifdef CLK_DIV_STB_EN
  logic               r_stb;
  logic               w_stb_nxt;
`endif

  assign w_hi      = P_CNT_W'(f_hi_cnt(32'(r_div)));
  assign w_wrap    = (r_state == ST_RUN) && (r_cnt == r_div - C_ONE);
  // IDLE applies a pending divisor in the same edge, so the start decision uses it.
  assign w_div_eff = r_pend_vld ? r_pend_div : r_div;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_en && (w_div_eff >= C_DIV_MIN)) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_wrap && (!i_en || (r_pend_vld && (r_pend_div < C_DIV_MIN))))
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_clk_nxt = 1'b0;
    w_apply   = r_pend_vld;
    w_cnt_clr = 1'b1;
`ifdef CLK_DIV_STB_EN
    w_stb_nxt = 1'b0;
`endif
    if (r_state == ST_RUN) begin
      w_clk_nxt = (r_cnt < w_hi);
      w_apply   = r_pend_vld && w_wrap;
      w_cnt_clr = w_wrap;
`ifdef CLK_DIV_STB_EN
      w_stb_nxt = (r_cnt == '0);
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt      <= '0;
      r_div      <= C_DIV_RST;
      r_pend_div <= C_DIV_RST;
      r_pend_vld <= 1'b0;
      r_clk      <= 1'b0;
    end else begin
      r_cnt <= w_cnt_clr ? '0 : r_cnt + C_ONE;
      r_clk <= w_clk_nxt;
      if (w_apply) r_div <= r_pend_div;
      // A write is only accepted while nothing is pending, so it never meets w_apply.
      if (i_wr) begin
        r_pend_div <= i_wr_div;
        r_pend_vld <= 1'b1;
      end else if (w_apply) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

`ifdef CLK_DIV_STB_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) r_stb <= 1'b0;
    else       r_stb <= w_stb_nxt;
  end

  assign o_rise_stb = r_stb;
`endif

  assign o_clk      = r_clk;
  assign o_pend_vld = r_pend_vld;
endmodule

// File: rtl/clk_div_bank.sv
// Bank of P_CH_NUM programmable clock dividers sharing one divisor write port.
// Define CLK_DIV_STB_EN to add the per-channel rising-edge strobe output.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int P_CH_NUM   = C_CH_NUM,
  parameter int P_CNT_W    = C_CNT_W,
  parameter int P_DIV_INIT = C_DIV_INIT
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [P_CH_NUM-1:0] i_ch_en,
  clk_div_bank_if.slave       cfg_if,
  output logic [P_CH_NUM-1:0] o_clk_div
`ifdef CLK_DIV_STB_EN
  ,
  output logic [P_CH_NUM-1:0] o_rise_stb
`endif
);
  localparam int CH_W   = f_ch_w(P_CH_NUM);
  localparam int CH_PAD = 1 << CH_W;

  logic [P_CH_NUM-1:0] w_pend_vld;
  logic [CH_PAD-1:0]   w_pend_pad;
  logic                w_ready;
  logic                w_accept;

  // Unpopulated select codes read as never pending: such writes are accepted and dropped.
  assign w_pend_pad         = CH_PAD'(w_pend_vld);
  assign w_ready            = !w_pend_pad[cfg_if.i_cfg_ch];
  assign w_accept           = cfg_if.i_cfg_valid && w_ready;
  assign cfg_if.o_cfg_ready = w_ready;

  for (genvar g = 0; g < P_CH_NUM; g++) begin : g_ch
    clk_div_ch #(
      .P_CNT_W   (P_CNT_W),
      .P_DIV_INIT(P_DIV_INIT)
    ) u_ch (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_en      (i_ch_en[g]),
      .i_wr      (w_accept && (cfg_if.i_cfg_ch == CH_W'(g))),
      .i_wr_div  (cfg_if.i_cfg_div),
      .o_pend_vld(w_pend_vld[g]),
      .o_clk     (o_clk_div[g])
`ifdef CLK_DIV_STB_EN
      ,
      .o_rise_stb(o_rise_stb[g])
`endif
    );
  end
endmodule

// File: tb/tb_clk_div_bank.sv
// Scenario bench for clk_div_bank: expected per-cycle outputs are queued from the
// divider's duty-cycle rules and popped against the DUT each cycle.
module tb_clk_div_bank;
  localparam int N = 4;

  typedef struct {
    logic [N-1:0] vec;
    logic [N-1:0] stb;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] en;
  logic [N-1:0] clk_div;
`ifdef CLK_DIV_STB_EN
  logic [N-1:0] rise_stb;
`endif

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  clk_div_bank_if #(.P_CH_NUM(N), .P_CNT_W(16)) cfg_if ();

  clk_div_bank #(.P_CH_NUM(N), .P_CNT_W(16), .P_DIV_INIT(2)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_ch_en  (en),
    .cfg_if   (cfg_if),
    .o_clk_div(clk_div)
`ifdef CLK_DIV_STB_EN
    ,
    .o_rise_stb(rise_stb)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_period(input int ch, input int d, input int n);
    exp_t e;
    int   hi;
    hi = d - d / 2;
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < d; c++) begin
        e.vec = '0;
        e.stb = '0;
        if (c < hi) e.vec[ch] = 1'b1;
        if (c == 0) e.stb[ch] = 1'b1;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic push_zeros(input int n);
    exp_t e;
    e.vec = '0;
    e.stb = '0;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic pop_exp(output exp_t e);
    if (exp_q.size() == 0) begin
      e.vec = 'x;
      e.stb = 'x;
    end else begin
      e = exp_q.pop_front();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = '0;
    cfg_if.i_cfg_valid = 1'b0;
    exp_q.delete();
    tick();
    rst = 1'b0;
  endtask

  task automatic cfg_write(input int ch, input int d);
    cfg_if.i_cfg_valid = 1'b1;
    cfg_if.i_cfg_ch    = 2'(ch);
    cfg_if.i_cfg_div   = 16'(d);
    tick();
    cfg_if.i_cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = '0;
    tick();
    tick();
    n_checks++;
    if (clk_div !== '0) begin
      n_fail++; $display("FAIL reset_clk: got %b want 0000", clk_div);
    end
    n_checks++;
    if (cfg_if.o_cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b want 1", cfg_if.o_cfg_ready);
    end
`ifdef CLK_DIV_STB_EN
    n_checks++;
    if (rise_stb !== '0) begin
      n_fail++; $display("FAIL reset_stb: got %b want 0000", rise_stb);
    end
`endif
    rst = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (clk_div !== '0) begin
      n_fail++; $display("FAIL idle_clk: got %b want 0000", clk_div);
    end
  endtask

  task automatic test_div2();
    exp_t e;
    do_reset();
    en = 4'b0001;
    tick();
    n_checks++;
    if (clk_div !== '0) begin
      n_fail++; $display("FAIL div2_latency: got %b want 0000", clk_div);
    end
    push_period(0, 2, 4);
    for (int i = 0; i < 8; i++) begin
      tick(); pop_exp(e);
      n_checks++;
      if (clk_div !== e.vec) begin
        n_fail++; $display("FAIL div2_clk cyc %0d: got %b want %b", i, clk_div, e.vec);
      end
`ifdef CLK_DIV_STB_EN
      n_checks++;
      if (rise_stb !== e.stb) begin
        n_fail++; $display("FAIL div2_stb cyc %0d: got %b want %b", i, rise_stb, e.stb);
      end
`endif
    end
  endtask

  task automatic test_div5();
    exp_t e;
    do_reset();
    cfg_if.i_cfg_ch = 2'd1;
    #1;
    n_checks++;
    if (cfg_if.o_cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL div5_ready_pre: got %b want 1", cfg_if.o_cfg_ready);
    end
    cfg_write(1, 5);
    n_checks++;
    if (cfg_if.o_cfg_ready !== 1'b0) begin
      n_fail++; $display("FAIL div5_ready_pend: got %b want 0", cfg_if.o_cfg_ready);
    end
    tick();
    n_checks++;
    if (cfg_if.o_cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL div5_ready_post: got %b want 1", cfg_if.o_cfg_ready);
    end
    en = 4'b0010;
    tick();
    n_checks++;
    if (clk_div !== '0) begin
      n_fail++; $display("FAIL div5_latency: got %b want 0000", clk_div);
    end
    push_period(1, 5, 3);
    for (int i = 0; i < 15; i++) begin
      tick(); pop_exp(e);
      n_checks++;
      if (clk_div !== e.vec) begin
        n_fail++; $display("FAIL div5_clk cyc %0d: got %b want %b", i, clk_div, e.vec);
      end
`ifdef CLK_DIV_STB_EN
      n_checks++;
      if (rise_stb !== e.stb) begin
        n_fail++; $display("FAIL div5_stb cyc %0d: got %b want %b", i, rise_stb, e.stb);
      end
`endif
    end
  endtask

  task automatic test_change();
    exp_t e;
    do_reset();
    cfg_write(2, 4);
    tick();
    en = 4'b0100;
    tick();
    n_checks++;
    if (clk_div !== '0) begin
      n_fail++; $display("FAIL chg_latency: got %b want 0000", clk_div);
    end
    push_period(2, 4, 1);
    push_period(2, 6, 2);
    for (int i = 0; i < 16; i++) begin
      tick(); pop_exp(e);
      n_checks++;
      if (clk_div !== e.vec) begin
        n_fail++; $display("FAIL chg_clk cyc %0d: got %b want %b", i, clk_div, e.vec);
      end
`ifdef CLK_DIV_STB_EN
      n_checks++;
      if (rise_stb !== e.stb) begin
        n_fail++; $display("FAIL chg_stb cyc %0d: got %b want %b", i, rise_stb, e.stb);
      end
`endif
      if (i == 0) begin
        cfg_if.i_cfg_valid = 1'b1;
        cfg_if.i_cfg_ch    = 2'd2;
        cfg_if.i_cfg_div   = 16'd6;
        #0;
        n_checks++;
        if (cfg_if.o_cfg_ready !== 1'b1) begin
          n_fail++; $display("FAIL chg_ready_first: got %b want 1", cfg_if.o_cfg_ready);
        end
      end
      if (i == 1) begin
        cfg_if.i_cfg_div = 16'd7;
        #0;
        n_checks++;
        if (cfg_if.o_cfg_ready !== 1'b0) begin
          n_fail++; $display("FAIL chg_ready_second: got %b want 0", cfg_if.o_cfg_ready);
        end
        cfg_if.i_cfg_valid = 1'b0;
      end
    end
  endtask

  task automatic test_disable();
    exp_t e;
    do_reset();
    cfg_write(3, 8);
    tick();
    en = 4'b1000;
    tick();
    n_checks++;
    if (clk_div !== '0) begin
      n_fail++; $display("FAIL dis_latency: got %b want 0000", clk_div);
    end
    push_period(3, 8, 1);
    push_zeros(10);
    for (int i = 0; i < 18; i++) begin
      tick(); pop_exp(e);
      n_checks++;
      if (clk_div !== e.vec) begin
        n_fail++; $display("FAIL dis_clk cyc %0d: got %b want %b", i, clk_div, e.vec);
      end
`ifdef CLK_DIV_STB_EN
      n_checks++;
      if (rise_stb !== e.stb) begin
        n_fail++; $display("FAIL dis_stb cyc %0d: got %b want %b", i, rise_stb, e.stb);
      end
`endif
      if (i == 1) en = 4'b0000;
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    do_reset();
    en = 4'b0001;
    tick();
    push_period(0, 2, 2);
    push_zeros(5);
    for (int i = 0; i < 9; i++) begin
      tick(); pop_exp(e);
      n_checks++;
      if (clk_div !== e.vec) begin
        n_fail++; $display("FAIL ill_clk cyc %0d: got %b want %b", i, clk_div, e.vec);
      end
      if (i == 0) begin
        cfg_if.i_cfg_valid = 1'b1;
        cfg_if.i_cfg_ch    = 2'd0;
        cfg_if.i_cfg_div   = 16'd1;
      end
      if (i == 1) begin
        cfg_if.i_cfg_valid = 1'b0;
        n_checks++;
        if (cfg_if.o_cfg_ready !== 1'b0) begin
          n_fail++; $display("FAIL ill_ready_pend: got %b want 0", cfg_if.o_cfg_ready);
        end
      end
      if (i == 4) begin
        n_checks++;
        if (cfg_if.o_cfg_ready !== 1'b1) begin
          n_fail++; $display("FAIL ill_ready_free: got %b want 1", cfg_if.o_cfg_ready);
        end
      end
    end
    cfg_write(0, 3);
    n_checks++;
    if (clk_div !== '0) begin
      n_fail++; $display("FAIL ill_resume_wr: got %b want 0000", clk_div);
    end
    push_zeros(1);
    push_period(0, 3, 2);
    for (int i = 0; i < 7; i++) begin
      tick(); pop_exp(e);
      n_checks++;
      if (clk_div !== e.vec) begin
        n_fail++; $display("FAIL ill_resume_clk cyc %0d: got %b want %b", i, clk_div, e.vec);
      end
`ifdef CLK_DIV_STB_EN
      n_checks++;
      if (rise_stb !== e.stb) begin
        n_fail++; $display("FAIL ill_resume_stb cyc %0d: got %b want %b", i, rise_stb, e.stb);
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    do_reset();
    cfg_write(1, 6);
    tick();
    en = 4'b0010;
    tick();
    tick();
    n_checks++;
    if (clk_div !== 4'b0010) begin
      n_fail++; $display("FAIL rmid_running: got %b want 0010", clk_div);
    end
    cfg_write(1, 3);
    n_checks++;
    if (cfg_if.o_cfg_ready !== 1'b0) begin
      n_fail++; $display("FAIL rmid_ready_pend: got %b want 0", cfg_if.o_cfg_ready);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (clk_div !== '0) begin
      n_fail++; $display("FAIL rmid_clk: got %b want 0000", clk_div);
    end
    n_checks++;
    if (cfg_if.o_cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL rmid_ready: got %b want 1", cfg_if.o_cfg_ready);
    end
`ifdef CLK_DIV_STB_EN
    n_checks++;
    if (rise_stb !== '0) begin
      n_fail++; $display("FAIL rmid_stb: got %b want 0000", rise_stb);
    end
`endif
    rst = 1'b0;
    tick();
    push_period(1, 2, 3);
    for (int i = 0; i < 6; i++) begin
      tick(); pop_exp(e);
      n_checks++;
      if (clk_div !== e.vec) begin
        n_fail++; $display("FAIL rmid_after cyc %0d: got %b want %b", i, clk_div, e.vec);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = '0;
    cfg_if.i_cfg_valid = 1'b0;
    cfg_if.i_cfg_ch    = '0;
    cfg_if.i_cfg_div   = '0;
    test_reset();
    test_div2();
    test_div5();
    test_change();
    test_disable();
    test_illegal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
